// File: rtl/ula_pkg.sv
// Shared definitions for the ULA result path: FSM state encoding, flag bit
// positions and default datapath sizing.
package ula_pkg;

  // Default data width of the ULA result and of the held value
  localparam int WIDTH_PADRAO = 8;

  // Largest supported ULA latency (executar to valid resultado_ula)
  localparam int LATENCIA_MAX = 3;

  // Flag bit positions inside the 4-bit {Z,N,C,V} flag word
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Result register controller states
  typedef enum logic [1:0] {
    INICIAL   = 2'd0,
    AGUARDA   = 2'd1,
    ENCADEADO = 2'd2
  } estado_t;

endpackage

// File: rtl/registrador_resultado_pilha_historico.sv
// pilha_historico: circular LIFO of previous results used for undo.
// When full, a push overwrites the oldest entry. dado_out always shows the
// most recent entry; pop discards it. limpar empties the stack synchronously.
module pilha_historico
  import ula_pkg::*;
#(
  parameter int W    = 12,
  parameter int PROF = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         limpar,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] dado_in,
  output logic [W-1:0] dado_out,
  output logic         vazio
);

  localparam int PW = (PROF > 1) ? $clog2(PROF) : 1;
  localparam int OW = $clog2(PROF + 1);
  localparam logic [PW-1:0] ULTIMO = PW'(PROF - 1);
  localparam logic [OW-1:0] CHEIO  = OW'(PROF);
  localparam logic [OW-1:0] UM     = OW'(1);

  logic [W-1:0]  mem_r [PROF];
  logic [PW-1:0] topo_r;
  logic [PW-1:0] prox_s;
  logic [PW-1:0] ant_s;
  logic [OW-1:0] ocup_r;
  logic          vazio_r;

  // Circular neighbours of the write pointer; ant_s addresses the newest entry
  always_comb begin
    prox_s = (topo_r == ULTIMO) ? {PW{1'b0}} : topo_r + {{(PW-1){1'b0}}, 1'b1};
    ant_s  = (topo_r == {PW{1'b0}}) ? ULTIMO : topo_r - {{(PW-1){1'b0}}, 1'b1};
  end

  assign dado_out = mem_r[ant_s];
  assign vazio    = vazio_r;

  // Pointer, occupancy and storage update; push wraps over the oldest entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PROF; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      topo_r  <= {PW{1'b0}};
      ocup_r  <= {OW{1'b0}};
      vazio_r <= 1'b1;
    end else if (limpar) begin
      topo_r  <= {PW{1'b0}};
      ocup_r  <= {OW{1'b0}};
      vazio_r <= 1'b1;
    end else if (push) begin
      mem_r[topo_r] <= dado_in;
      topo_r        <= prox_s;
      ocup_r        <= (ocup_r == CHEIO) ? CHEIO : ocup_r + UM;
      vazio_r       <= 1'b0;
    end else if (pop && !vazio_r) begin
      topo_r  <= ant_s;
      ocup_r  <= ocup_r - UM;
      vazio_r <= (ocup_r == UM);
    end else begin
      topo_r  <= topo_r;
      ocup_r  <= ocup_r;
      vazio_r <= vazio_r;
    end
  end

endmodule

// File: rtl/registrador_resultado.sv
// registrador_resultado: result register and chaining controller at the ULA
// output. Holds the previous result and flags and drives the first-operand
// select (sel=0 first operation, sel=1 chained on the held result).
// Optional undo history enabled by defining REGISTRADOR_HISTORICO_EN.
module registrador_resultado
  import ula_pkg::*;
#(
  parameter int WIDTH     = WIDTH_PADRAO,
  parameter int LATENCIA  = 1,
  parameter int CONT_W    = 4,
  parameter int PROF_HIST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              executar,
  input  logic              limpar,
  input  logic              desfazer,
  input  logic [WIDTH-1:0]  resultado_ula,
  input  logic [3:0]        flags_ula,
  output logic [WIDTH-1:0]  resultado_anterior,
  output logic [3:0]        flags_reg,
  output logic              sel,
  output logic              ocupado,
  output logic              valido,
  output logic [CONT_W-1:0] num_ops,
  output logic              hist_vazio
);

  localparam logic [1:0]        CNT_INI = (LATENCIA > 0) ? 2'(LATENCIA - 1) : 2'd0;
  localparam logic [CONT_W-1:0] OPS_UM  = CONT_W'(1);
  localparam logic [CONT_W-1:0] OPS_MAX = {CONT_W{1'b1}};

  estado_t           state_r, state_n;
  logic [1:0]        cnt_r, cnt_n;
  logic [WIDTH-1:0]  res_r, res_n;
  logic [3:0]        flags_r, flags_n;
  logic              sel_r, sel_n;
  logic              ocupado_r, ocupado_n;
  logic              valido_r, valido_n;
  logic [CONT_W-1:0] ops_r, ops_n;
  logic              captura_s;
  logic              push_s;
  logic              pop_s;
  logic              limpa_hist_s;
  logic              hist_vazio_s;

  // Saturating increment of the operation counter
  function automatic logic [CONT_W-1:0] inc_sat(input logic [CONT_W-1:0] v);
    inc_sat = (v == OPS_MAX) ? OPS_MAX : v + OPS_UM;
  endfunction

`ifdef REGISTRADOR_HISTORICO_EN
  logic [WIDTH+3:0] hist_topo_s;

  pilha_historico #(
    .W    (WIDTH + 4),
    .PROF (PROF_HIST)
  ) u_pilha (
    .clk      (clk),
    .reset    (reset),
    .limpar   (limpa_hist_s),
    .push     (push_s),
    .pop      (pop_s),
    .dado_in  ({res_r, flags_r}),
    .dado_out (hist_topo_s),
    .vazio    (hist_vazio_s)
  );
`else
  logic hist_unused_s;
  assign hist_vazio_s  = 1'b1;
  assign hist_unused_s = ^{desfazer, push_s, pop_s, limpa_hist_s};
`endif

  // Next-state, capture and undo decisions; limpar overrides everything
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    res_n        = res_r;
    flags_n      = flags_r;
    sel_n        = sel_r;
    ocupado_n    = ocupado_r;
    valido_n     = valido_r;
    ops_n        = ops_r;
    captura_s    = 1'b0;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    limpa_hist_s = 1'b0;

    case (state_r)
      INICIAL, ENCADEADO: begin
        if (executar) begin
          if (LATENCIA == 0) begin
            captura_s = 1'b1;
          end else begin
            // sel is left untouched: it keeps the mode the request came from
            state_n   = AGUARDA;
            ocupado_n = 1'b1;
            cnt_n     = CNT_INI;
          end
        end
`ifdef REGISTRADOR_HISTORICO_EN
        else if (desfazer && (state_r == ENCADEADO)) begin
          if (!hist_vazio_s) begin
            pop_s   = 1'b1;
            res_n   = hist_topo_s[WIDTH+3:4];
            flags_n = hist_topo_s[3:0];
            ops_n   = (ops_r > OPS_UM) ? ops_r - OPS_UM : OPS_UM;
          end else begin
            state_n  = INICIAL;
            sel_n    = 1'b0;
            valido_n = 1'b0;
            ops_n    = {CONT_W{1'b0}};
          end
        end
`endif
        else begin
          state_n = state_r;
        end
      end
      AGUARDA: begin
        if (cnt_r == 2'd0) begin
          captura_s = 1'b1;
        end else begin
          cnt_n = cnt_r - 2'd1;
        end
      end
      default: begin
        state_n   = INICIAL;
        cnt_n     = 2'd0;
        sel_n     = 1'b0;
        ocupado_n = 1'b0;
        valido_n  = 1'b0;
        ops_n     = {CONT_W{1'b0}};
      end
    endcase

    if (captura_s) begin
      // Only chained captures have a meaningful previous result to save
      push_s    = sel_r;
      state_n   = ENCADEADO;
      cnt_n     = 2'd0;
      res_n     = resultado_ula;
      flags_n   = flags_ula;
      sel_n     = 1'b1;
      ocupado_n = 1'b0;
      valido_n  = 1'b1;
      ops_n     = inc_sat(ops_r);
    end else begin
      push_s = 1'b0;
    end

    if (limpar) begin
      // Held result and flags survive; the pending capture is discarded
      state_n      = INICIAL;
      cnt_n        = 2'd0;
      res_n        = res_r;
      flags_n      = flags_r;
      sel_n        = 1'b0;
      ocupado_n    = 1'b0;
      valido_n     = 1'b0;
      ops_n        = {CONT_W{1'b0}};
      push_s       = 1'b0;
      pop_s        = 1'b0;
      limpa_hist_s = 1'b1;
    end else begin
      limpa_hist_s = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= INICIAL;
      cnt_r     <= 2'd0;
      res_r     <= {WIDTH{1'b0}};
      flags_r   <= 4'd0;
      sel_r     <= 1'b0;
      ocupado_r <= 1'b0;
      valido_r  <= 1'b0;
      ops_r     <= {CONT_W{1'b0}};
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      res_r     <= res_n;
      flags_r   <= flags_n;
      sel_r     <= sel_n;
      ocupado_r <= ocupado_n;
      valido_r  <= valido_n;
      ops_r     <= ops_n;
    end
  end

  assign resultado_anterior = res_r;
  assign flags_reg          = flags_r;
  assign sel                = sel_r;
  assign ocupado            = ocupado_r;
  assign valido             = valido_r;
  assign num_ops            = ops_r;
  assign hist_vazio         = hist_vazio_s;

endmodule
